softmax_rr_scheduler: RTL and testbench



---
 rtl/softmax_rr_scheduler.sv | 177 +++++++++++++++++
 tb/tb_softmax_rr_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_rr_scheduler.sv
// softmax_rr_scheduler
//   Shares one softmax engine among NUM_REQ requesters. Requests are granted
//   round-robin. The engine input handshake takes two cycles per vector: IDLE
//   picks the requester, and ISSUE presents the captured vector to the engine.
//   The requester index of every accepted vector goes into an in-order tag
//   FIFO. Each engine result is then returned, one cycle later, tagged with
//   the requester that issued it.
//
// Ports
//   aclk, rst         clock, synchronous active-high reset
//   req_tvalid/tdata  per-requester vectors (requester k at [k*DATA_W +: DATA_W])
//   req_tready        per-requester accept (only the granted bit, mirrors eng_tready)
//   eng_tvalid/tdata  engine input stream; eng_tready from engine
//   eng_dout_tvalid   engine result valid, with eng_dout_tdata / eng_max_id
//   res_*             tagged result, single-cycle pulse, no backpressure
//   busy              in ISSUE or results still outstanding
//   err_orphan        sticky, engine result arrived with no tag held
//
// Optional: define SOFTMAX_SCHED_STATS_EN to add stat_cnt (per-requester
//   completed-result counters, 16 bits each) and stat_stall (ISSUE cycles
//   with eng_tready low). Both counters saturate.
//
// state | meaning
// IDLE  | choose next requester if one is valid and the engine has room
// ISSUE | vector presented to engine, waiting for eng_tready
module softmax_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 520,
    parameter int TAG_W   = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_tvalid,
    input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
    output logic [NUM_REQ-1:0]        req_tready,
    output logic                      eng_tvalid,
    output logic [DATA_W-1:0]         eng_tdata,
    input  logic                      eng_tready,
    input  logic                      eng_dout_tvalid,
    input  logic [15:0]               eng_dout_tdata,
    input  logic [7:0]                eng_max_id,
    output logic                      res_tvalid,
    output logic [15:0]               res_tdata,
    output logic [7:0]                res_max_id,
    output logic [TAG_W-1:0]          res_tag,
    output logic                      busy,
    output logic                      err_orphan
`ifdef SOFTMAX_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_cnt,
    output logic [15:0]               stat_stall
`endif
);

    localparam int AW = $clog2(MAX_OUT);
    localparam int PW = AW + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]        state;
    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  grant;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     outstanding;
    logic [TAG_W-1:0]  tag_mem [MAX_OUT];

    logic              found;
    logic [TAG_W-1:0]  pick;
    logic [DATA_W-1:0] pick_data;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              can_issue;

    // The extra pointer bit tells full apart from empty. The subtraction
    // wraps correctly because both pointers wrap at 2*MAX_OUT.
    assign outstanding = wr_ptr - rd_ptr;
    assign fifo_empty  = (outstanding == '0);
    assign can_issue   = (outstanding < PW'(MAX_OUT));
    assign push        = (state == S_ISSUE) && eng_tready;
    assign pop         = eng_dout_tvalid && !fifo_empty;
    assign eng_tvalid  = (state == S_ISSUE);
    assign busy        = (state == S_ISSUE) || !fifo_empty;

    // Round-robin search. The distance from rr_ptr decides priority. Scanning
    // the distance from high to low lets the closest valid requester win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_tvalid[k] && (((k - int'(rr_ptr) + NUM_REQ) % NUM_REQ) == i)) begin
                    found = 1'b1;
                    pick  = TAG_W'(k);
                end
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == TAG_W'(k)) pick_data = req_tdata[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        req_tready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((state == S_ISSUE) && (grant == TAG_W'(k))) req_tready[k] = eng_tready;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            eng_tdata  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            res_tvalid <= 1'b0;
            res_tdata  <= '0;
            res_max_id <= '0;
            res_tag    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (found && can_issue) begin
                    grant     <= pick;
                    eng_tdata <= pick_data;
                    state     <= S_ISSUE;
                end
            end else if (eng_tready) begin
                rr_ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
                state  <= S_IDLE;
            end

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            res_tvalid <= pop;
            if (pop) begin
                res_tdata  <= eng_dout_tdata;
                res_max_id <= eng_max_id;
                res_tag    <= tag_mem[rd_ptr[AW-1:0]];
            end

            if (eng_dout_tvalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    // Tag storage needs no reset. The pointers alone decide which entries are valid.
    always_ff @(posedge aclk) begin
        if (push) tag_mem[wr_ptr[AW-1:0]] <= grant;
    end

`ifdef SOFTMAX_SCHED_STATS_EN
    always_ff @(posedge aclk) begin
        if (rst) begin
            stat_cnt   <= '0;
            stat_stall <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (res_tvalid && (res_tag == TAG_W'(k)) && (stat_cnt[k*16 +: 16] != 16'hFFFF))
                    stat_cnt[k*16 +: 16] <= stat_cnt[k*16 +: 16] + 16'd1;
            end
            if ((state == S_ISSUE) && !eng_tready && (stat_stall != 16'hFFFF))
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_softmax_rr_scheduler.sv
// Testbench for softmax_rr_scheduler: a table of per-cycle vectors, followed by
// hand-written sequences for stall, full FIFO, orphan and mid-flight reset.
module tb_softmax_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 520;
    localparam int TAG_W   = 2;
    localparam int MAX_OUT = 8;

    logic                      aclk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic [NUM_REQ-1:0]        req_tready;
    logic                      eng_tvalid;
    logic [DATA_W-1:0]         eng_tdata;
    logic                      eng_tready;
    logic                      eng_dout_tvalid;
    logic [15:0]               eng_dout_tdata;
    logic [7:0]                eng_max_id;
    logic                      res_tvalid;
    logic [15:0]               res_tdata;
    logic [7:0]                res_max_id;
    logic [TAG_W-1:0]          res_tag;
    logic                      busy;
    logic                      err_orphan;
`ifdef SOFTMAX_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0]     stat_cnt;
    logic [15:0]               stat_stall;
`endif

    always #5 aclk = ~aclk;

    softmax_rr_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .aclk(aclk), .rst(rst),
        .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tready(req_tready),
        .eng_tvalid(eng_tvalid), .eng_tdata(eng_tdata), .eng_tready(eng_tready),
        .eng_dout_tvalid(eng_dout_tvalid), .eng_dout_tdata(eng_dout_tdata),
        .eng_max_id(eng_max_id),
        .res_tvalid(res_tvalid), .res_tdata(res_tdata), .res_max_id(res_max_id),
        .res_tag(res_tag), .busy(busy), .err_orphan(err_orphan)
`ifdef SOFTMAX_SCHED_STATS_EN
        , .stat_cnt(stat_cnt), .stat_stall(stat_stall)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        rdy;
        logic        dv;
        logic [15:0] dd;
        logic [7:0]  dm;
        logic        e_ev;
        int          e_g;
        logic [3:0]  e_rtr;
        logic        e_res;
        logic [1:0]  e_tag;
        logic [15:0] e_rd;
        logic [7:0]  e_rm;
        logic        e_busy;
        logic        e_orph;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic rdy,
                                input logic dv, input logic [15:0] dd, input logic [7:0] dm,
                                input logic ev, input int g, input logic [3:0] rtr,
                                input logic res, input logic [1:0] tag, input logic [15:0] rd,
                                input logic [7:0] rm, input logic bsy, input logic orph);
        vec_t v;
        v.rst = r; v.vld = vld; v.rdy = rdy; v.dv = dv; v.dd = dd; v.dm = dm;
        v.e_ev = ev; v.e_g = g; v.e_rtr = rtr; v.e_res = res; v.e_tag = tag;
        v.e_rd = rd; v.e_rm = rm; v.e_busy = bsy; v.e_orph = orph;
        return v;
    endfunction

    // Requester k sends a vector filled with the byte A4+k (requester 1 -> ...A5).
    function automatic logic [DATA_W-1:0] pat(input int k);
        logic [DATA_W-1:0] v;
        logic [7:0] b;
        b = 8'hA4 + 8'(k);
        v = '0;
        for (int j = 0; j < DATA_W / 8; j++) v[j*8 +: 8] = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act[31:0], exp[31:0]);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_in();
        req_tvalid      = '0;
        eng_tready      = 1'b0;
        eng_dout_tvalid = 1'b0;
        eng_dout_tdata  = '0;
        eng_max_id      = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int issues;

    initial begin
        rst = 1'b1;
        idle_in();
        for (int k = 0; k < NUM_REQ; k++) req_tdata[k*DATA_W +: DATA_W] = pat(k);

        //             rst vld    rdy dv dd        dm     ev g  rtr     res tag rd        rm     busy orph
        tbl[0]  = mk(1, 4'b0000, 0, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 0, 0);
        tbl[1]  = mk(0, 4'b0010, 1, 0, 16'h0000, 8'h00, 1, 1, 4'b0010, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[2]  = mk(0, 4'b0010, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[3]  = mk(0, 4'b0000, 1, 1, 16'h7F00, 8'h03, 0, 0, 4'b0000, 1, 1, 16'h7F00, 8'h03, 0, 0);
        tbl[4]  = mk(0, 4'b0000, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 0, 0);
        tbl[5]  = mk(1, 4'b0000, 0, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 0, 0);
        tbl[6]  = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 0, 4'b0001, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[7]  = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[8]  = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 1, 4'b0010, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[9]  = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[10] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 2, 4'b0100, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[11] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[12] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 3, 4'b1000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[13] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[14] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 0, 4'b0001, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[15] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[16] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 1, 1, 4'b0010, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[17] = mk(0, 4'b1111, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);
        tbl[18] = mk(0, 4'b0000, 1, 1, 16'h1111, 8'h05, 0, 0, 4'b0000, 1, 0, 16'h1111, 8'h05, 1, 0);
        tbl[19] = mk(0, 4'b0000, 1, 1, 16'h2222, 8'h06, 0, 0, 4'b0000, 1, 1, 16'h2222, 8'h06, 1, 0);
        tbl[20] = mk(0, 4'b0000, 1, 0, 16'h0000, 8'h00, 0, 0, 4'b0000, 0, 0, 16'h0000, 8'h00, 1, 0);

        for (int i = 0; i < 21; i++) begin
            rst             = tbl[i].rst;
            req_tvalid      = tbl[i].vld;
            eng_tready      = tbl[i].rdy;
            eng_dout_tvalid = tbl[i].dv;
            eng_dout_tdata  = tbl[i].dd;
            eng_max_id      = tbl[i].dm;
            step();
            chk($sformatf("v%0d eng_tvalid", i), 32'(eng_tvalid), 32'(tbl[i].e_ev));
            if (tbl[i].e_ev)
                chk_data($sformatf("v%0d eng_tdata", i), eng_tdata, pat(tbl[i].e_g));
            chk($sformatf("v%0d req_tready", i), 32'(req_tready), 32'(tbl[i].e_rtr));
            chk($sformatf("v%0d res_tvalid", i), 32'(res_tvalid), 32'(tbl[i].e_res));
            if (tbl[i].e_res) begin
                chk($sformatf("v%0d res_tag", i), 32'(res_tag), 32'(tbl[i].e_tag));
                chk($sformatf("v%0d res_tdata", i), 32'(res_tdata), 32'(tbl[i].e_rd));
                chk($sformatf("v%0d res_max_id", i), 32'(res_max_id), 32'(tbl[i].e_rm));
            end
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d err_orphan", i), 32'(err_orphan), 32'(tbl[i].e_orph));
        end
`ifdef SOFTMAX_SCHED_STATS_EN
        chk("stat_cnt0", 32'(stat_cnt[15:0]), 32'd1);
        chk("stat_cnt1", 32'(stat_cnt[31:16]), 32'd1);
        chk("stat_cnt2", 32'(stat_cnt[47:32]), 32'd0);
        chk("stat_stall_rr", 32'(stat_stall), 32'd0);
`endif
        rst = 1'b0;

        // Stall: eng_tready low for 5 cycles in ISSUE.
        do_reset();
        req_tvalid = 4'b0001;
        step();
        chk("stall enter eng_tvalid", 32'(eng_tvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall%0d eng_tvalid", i), 32'(eng_tvalid), 32'd1);
            chk_data($sformatf("stall%0d eng_tdata", i), eng_tdata, pat(0));
            chk($sformatf("stall%0d req_tready", i), 32'(req_tready), 32'd0);
        end
        eng_tready = 1'b1;
        #1;
        chk("stall release req_tready", 32'(req_tready), 32'b0001);
        step();
        req_tvalid = '0;
        chk("stall done eng_tvalid", 32'(eng_tvalid), 32'd0);
        chk("stall done busy", 32'(busy), 32'd1);
`ifdef SOFTMAX_SCHED_STATS_EN
        chk("stat_stall", 32'(stat_stall), 32'd5);
`endif

        // Full: 8 issues, no results; the 9th waits for a pop.
        do_reset();
        req_tvalid = 4'b0001;
        eng_tready = 1'b1;
        issues = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (eng_tvalid && eng_tready) issues++;
        end
        chk("full issues", 32'(issues), 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("full%0d eng_tvalid", i), 32'(eng_tvalid), 32'd0);
            chk($sformatf("full%0d busy", i), 32'(busy), 32'd1);
        end
        eng_dout_tvalid = 1'b1;
        eng_dout_tdata  = 16'hABCD;
        eng_max_id      = 8'h07;
        step();
        eng_dout_tvalid = 1'b0;
        chk("full pop res_tvalid", 32'(res_tvalid), 32'd1);
        chk("full pop res_tag", 32'(res_tag), 32'd0);
        chk("full pop res_tdata", 32'(res_tdata), 32'hABCD);
        chk("full pop eng_tvalid", 32'(eng_tvalid), 32'd0);
        step();
        chk("full resume eng_tvalid", 32'(eng_tvalid), 32'd1);
        idle_in();

        // Orphan result after reset.
        do_reset();
        eng_dout_tvalid = 1'b1;
        eng_dout_tdata  = 16'h1234;
        step();
        eng_dout_tvalid = 1'b0;
        chk("orphan res_tvalid", 32'(res_tvalid), 32'd0);
        chk("orphan flag", 32'(err_orphan), 32'd1);
        step();
        step();
        chk("orphan sticky", 32'(err_orphan), 32'd1);
        do_reset();
        chk("orphan cleared", 32'(err_orphan), 32'd0);

        // Reset with 3 vectors in flight and a result arriving.
        req_tvalid = 4'b1111;
        eng_tready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("inflight busy", 32'(busy), 32'd1);
        rst             = 1'b1;
        eng_dout_tvalid = 1'b1;
        eng_dout_tdata  = 16'h5555;
        step();
        chk("rst eng_tvalid", 32'(eng_tvalid), 32'd0);
        chk("rst req_tready", 32'(req_tready), 32'd0);
        chk_data("rst eng_tdata", eng_tdata, '0);
        chk("rst res_tvalid", 32'(res_tvalid), 32'd0);
        chk("rst res_tdata", 32'(res_tdata), 32'd0);
        chk("rst res_max_id", 32'(res_max_id), 32'd0);
        chk("rst res_tag", 32'(res_tag), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err_orphan", 32'(err_orphan), 32'd0);
`ifdef SOFTMAX_SCHED_STATS_EN
        chk("rst stat_cnt", 32'(stat_cnt == '0), 32'd1);
        chk("rst stat_stall", 32'(stat_stall), 32'd0);
`endif
        rst = 1'b0;
        idle_in();
        step();
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst err_orphan", 32'(err_orphan), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
